// File: rtl/hd63701_phase_seq_pkg.sv
// Shared definitions for the HD63701 phase sequencer: phase codes,
// vector-select codes, IRQ bit positions and the execute-phase limit.
package hd63701_phase_seq_pkg;

   typedef enum logic [5:0] {
      PH_RST   = 6'd0,
      PH_VECT  = 6'd1,
      PH_VEC1  = 6'd2,
      PH_VEC2  = 6'd3,
      PH_FETCH = 6'd4,
      PH_SLEEP = 6'd5,
      PH_EXEC  = 6'd16,
      PH_EXEC1 = 6'd17,
      PH_EXEC2 = 6'd18,
      PH_EXEC3 = 6'd19,
      PH_EXEC4 = 6'd20,
      PH_EXEC5 = 6'd21,
      PH_EXEC6 = 6'd22,
      PH_EXEC7 = 6'd23,
      PH_EXEC8 = 6'd24,
      PH_EXEC9 = 6'd25,
      PH_INTR  = 6'd32,
      PH_INTR1 = 6'd33,
      PH_INTR2 = 6'd34,
      PH_INTR3 = 6'd35,
      PH_INTR4 = 6'd36,
      PH_INTR5 = 6'd37,
      PH_INTR6 = 6'd38,
      PH_INTR7 = 6'd39,
      PH_INTR8 = 6'd40,
      PH_INTR9 = 6'd41
   } phase_e;

   typedef enum logic [2:0] {
      VS_RST  = 3'd0,
      VS_NMI  = 3'd1,
      VS_IRQ1 = 3'd2,
      VS_ICF  = 3'd3,
      VS_OCF  = 3'd4,
      VS_TOF  = 3'd5,
      VS_SCI  = 3'd6,
      VS_TRAP = 3'd7
   } vsel_e;

   localparam int IRQ_IRQ1 = 4;
   localparam int IRQ_ICF  = 3;
   localparam int IRQ_OCF  = 2;
   localparam int IRQ_TOF  = 1;
   localparam int IRQ_SCI  = 0;

   // Index of the last execute phase; running past it means an illegal opcode.
   localparam int EXEC_MAX_DEF = 9;

endpackage

// File: rtl/hd63701_phase_seq_if.sv
// Bus between the phase sequencer and the rest of the core / microcode ROM.
// The sequencer sits on the slave side; the core (or a bench) on the master side.
interface hd63701_phase_seq_if;

   logic       ce;
   logic [7:0] din;
   logic       mc_end;
   logic       slp;
   logic       nmi;
   logic [4:0] irq;
   logic       imask;
   logic [5:0] phase;
   logic [7:0] opcode;
   logic [2:0] vsel;
   logic       illegal;

   modport master (
      output ce, din, mc_end, slp, nmi, irq, imask,
      input  phase, opcode, vsel, illegal
   );

   modport slave (
      input  ce, din, mc_end, slp, nmi, irq, imask,
      output phase, opcode, vsel, illegal
   );

endinterface

// File: rtl/hd63701_irq_prio.sv
// Combinational IRQ priority encoder: maps the five level requests to the
// vector select of the highest-priority pending source, plus an any-pending flag.
module hd63701_irq_prio
   import hd63701_phase_seq_pkg::*;
(
   input  logic [4:0] irq,
   output logic [2:0] vsel,
   output logic       any
);

   // Lowest priority is tested first so higher-priority sources overwrite it.
   always_comb begin
      vsel = VS_RST;
      if (irq[IRQ_SCI])  vsel = VS_SCI;
      if (irq[IRQ_TOF])  vsel = VS_TOF;
      if (irq[IRQ_OCF])  vsel = VS_OCF;
      if (irq[IRQ_ICF])  vsel = VS_ICF;
      if (irq[IRQ_IRQ1]) vsel = VS_IRQ1;
      any = |irq;
   end

endmodule

// File: rtl/hd63701_phase_seq.sv
// HD63701 phase sequencer. Produces the registered PHASE and OPCODE consumed
// by the microcode ROM, handles reset/interrupt vectoring, SLP sleep and the
// illegal-opcode trap, and picks the vector loaded during VECT/VEC1.
module hd63701_phase_seq
   import hd63701_phase_seq_pkg::*;
#(
   parameter int         EXEC_MAX   = EXEC_MAX_DEF,
   parameter logic [7:0] RST_OPCODE = 8'h01
)(
   input logic                clk,
   input logic                rst_n,
   hd63701_phase_seq_if.slave bus
);

   localparam logic [3:0] EXEC_LAST = 4'(EXEC_MAX);

   phase_e     state, state_d;
   logic [7:0] opcode, opcode_d;
   logic [2:0] vsel, vsel_d;
   logic       illegal;
   logic       trap;
   logic       nmi_q;
   logic       nmi_latch;
   logic       nmi_take;
   logic [2:0] prio_vsel;
   logic       irq_any;
   logic [3:0] exec_idx;

   hd63701_irq_prio u_prio (
      .irq  (bus.irq),
      .vsel (prio_vsel),
      .any  (irq_any)
   );

   assign exec_idx    = state[3:0];
   assign bus.phase   = state;
   assign bus.opcode  = opcode;
   assign bus.vsel    = vsel;
   assign bus.illegal = illegal;

   // Next phase, opcode and vector decision; nothing moves unless CE is high.
   always_comb begin
      state_d  = state;
      opcode_d = opcode;
      vsel_d   = vsel;
      trap     = 1'b0;
      nmi_take = 1'b0;
      if (bus.ce) begin
         case (state)
            PH_RST:   state_d = PH_VECT;
            PH_VECT:  state_d = PH_VEC1;
            PH_VEC1:  state_d = PH_VEC2;
            PH_VEC2:  state_d = PH_FETCH;
            PH_FETCH: begin
               if (nmi_latch) begin
                  state_d  = PH_INTR;
                  vsel_d   = VS_NMI;
                  nmi_take = 1'b1;
               end else if (!bus.imask && irq_any) begin
                  state_d = PH_INTR;
                  vsel_d  = prio_vsel;
               end else begin
                  state_d  = PH_EXEC;
                  opcode_d = bus.din;
               end
            end
            PH_SLEEP: begin
               if (nmi_latch) begin
                  state_d  = PH_INTR;
                  vsel_d   = VS_NMI;
                  nmi_take = 1'b1;
               end else if (irq_any && !bus.imask) begin
                  state_d = PH_INTR;
                  vsel_d  = prio_vsel;
               end else if (irq_any) begin
                  state_d = PH_FETCH;
               end
            end
            PH_EXEC, PH_EXEC1, PH_EXEC2, PH_EXEC3, PH_EXEC4,
            PH_EXEC5, PH_EXEC6, PH_EXEC7, PH_EXEC8, PH_EXEC9: begin
               if (bus.mc_end) begin
                  state_d = bus.slp ? PH_SLEEP : PH_FETCH;
               end else if (exec_idx < EXEC_LAST) begin
                  state_d = phase_e'(state + 6'd1);
               end else if (exec_idx == EXEC_LAST) begin
                  state_d = PH_INTR;
                  vsel_d  = VS_TRAP;
                  trap    = 1'b1;
               end else begin
                  state_d = PH_FETCH;
               end
            end
            PH_INTR, PH_INTR1, PH_INTR2, PH_INTR3,
            PH_INTR4, PH_INTR5, PH_INTR6: state_d = phase_e'(state + 6'd1);
            PH_INTR7: state_d = PH_VECT;
            default:  state_d = PH_FETCH;
         endcase
      end
   end

   // Phase, opcode and vector registers seen by the microcode ROM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= PH_RST;
         opcode <= RST_OPCODE;
         vsel   <= VS_RST;
      end else begin
         state  <= state_d;
         opcode <= opcode_d;
         vsel   <= vsel_d;
      end
   end

   // Every-clock logic: NMI edge latch (a new edge wins over consumption) and the trap pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nmi_q     <= bus.nmi;
         nmi_latch <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         nmi_q     <= bus.nmi;
         nmi_latch <= (nmi_latch & ~nmi_take) | (bus.nmi & ~nmi_q);
         illegal   <= trap;
      end
   end

endmodule
